// File: rtl/adda_pkg.sv
// rtl/adda_pkg.sv - shared constants and sizing helper for the J2 ADC/DAC stream blocks
package adda_pkg;

  localparam int ADDA_DATA_W = 8;
  localparam logic [7:0] ADDA_IDLE_CODE = 8'h80;

  // Pointer/level width: one extra bit so full and empty are distinguishable.
  function automatic int ctr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered flags, level and read data
module sync_fifo
  import adda_pkg::*;
#(
  parameter int              W       = 8,
  parameter int              DEPTH   = 16,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic                       i_clk,
  input  logic                       i_resetn,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [ctr_w(DEPTH)-1:0]    level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic          do_wr, do_rd;

  // Flags are registered, so a same-cycle push never makes an empty FIFO poppable.
  assign do_wr    = wr_en && !full;
  assign do_rd    = rd_en && !empty;
  assign wr_ptr_n = wr_ptr + PW'(do_wr);
  assign rd_ptr_n = rd_ptr + PW'(do_rd);

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      level   <= '0;
      rd_data <= RST_VAL;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      full   <= (wr_ptr_n[AW] != rd_ptr_n[AW]) && (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);
      empty  <= (wr_ptr_n == rd_ptr_n);
      level  <= wr_ptr_n - rd_ptr_n;
      if (do_rd) begin
        rd_data <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_wr) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/dac_stream_tx.sv
// rtl/dac_stream_tx.sv - buffered sample playout to the J2 parallel DAC at a programmable rate
module dac_stream_tx
  import adda_pkg::*;
#(
  parameter int                 DATA_W     = ADDA_DATA_W,
  parameter int                 DIV_W      = 16,
  parameter int                 FIFO_DEPTH = 16,
  parameter logic [DATA_W-1:0]  IDLE_CODE  = DATA_W'(ADDA_IDLE_CODE)
) (
  input  logic                              i_clk,
  input  logic                              i_resetn,
  input  logic                              i_enable,
  input  logic [DIV_W-1:0]                  i_div,
  input  logic                              s_valid,
  input  logic [DATA_W-1:0]                 s_data,
  output logic                              s_ready,
  output logic [DATA_W-1:0]                 o_da_port,
  output logic                              o_da_clk,
  output logic                              o_underrun,
  output logic [7:0]                        o_underrun_cnt,
  output logic [ctr_w(FIFO_DEPTH)-1:0]      o_level
);

  logic [DIV_W-1:0] div_q, ph, ph_nxt, pm1;
  logic [DIV_W:0]   half;
  logic             run, primed, primed_nxt, tick;
  logic             fifo_full, fifo_empty, push, pop;

  assign s_ready = !fifo_full;
  assign push    = s_valid && !fifo_full;
  assign pop     = tick && !fifo_empty;

  // P-1 and P/2 derived from the divider latched at the last wrap.
  assign pm1  = (div_q == '0) ? DIV_W'(1) : div_q;
  assign half = ({1'b0, pm1} + {{DIV_W{1'b0}}, 1'b1}) >> 1;

  // run delays counting by one cycle so ph is 0 in the first enabled cycle.
  assign tick       = i_enable && run && (ph == pm1);
  assign primed_nxt = i_enable && (primed || tick);

  always_comb begin
    ph_nxt = '0;
    if (i_enable && run && (ph != pm1)) begin
      ph_nxt = ph + DIV_W'(1);
    end
  end

  sync_fifo #(
    .W       (DATA_W),
    .DEPTH   (FIFO_DEPTH),
    .RST_VAL (IDLE_CODE)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_resetn (i_resetn),
    .wr_en    (push),
    .wr_data  (s_data),
    .rd_en    (pop),
    .rd_data  (o_da_port),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (o_level)
  );

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      div_q          <= DIV_W'(1);
      ph             <= '0;
      run            <= 1'b0;
      primed         <= 1'b0;
      o_da_clk       <= 1'b0;
      o_underrun     <= 1'b0;
      o_underrun_cnt <= '0;
    end else begin
      run    <= i_enable;
      ph     <= ph_nxt;
      primed <= primed_nxt;
      if (!i_enable || tick) begin
        div_q <= i_div;
      end
      // Latch clock stays low until the first slot has been presented.
      o_da_clk   <= primed_nxt && (ph_nxt != '0) && ({1'b0, ph_nxt} <= half);
      o_underrun <= tick && fifo_empty;
      if (tick && fifo_empty && (o_underrun_cnt != 8'hFF)) begin
        o_underrun_cnt <= o_underrun_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_dac_stream_tx.sv
// tb/tb_dac_stream_tx.sv - randomized and directed bench for dac_stream_tx against a queue model
module tb_dac_stream_tx;

  localparam int DW    = 8;
  localparam int VW    = 16;
  localparam int DEPTH = 16;
  localparam int LW    = 5;

  logic          i_clk = 1'b0;
  logic          i_resetn = 1'b0;
  logic          i_enable = 1'b0;
  logic [VW-1:0] i_div = 16'd1;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic [DW-1:0] o_da_port;
  logic          o_da_clk;
  logic          o_underrun;
  logic [7:0]    o_underrun_cnt;
  logic [LW-1:0] o_level;

  dac_stream_tx dut (
    .i_clk          (i_clk),
    .i_resetn       (i_resetn),
    .i_enable       (i_enable),
    .i_div          (i_div),
    .s_valid        (s_valid),
    .s_data         (s_data),
    .s_ready        (s_ready),
    .o_da_port      (o_da_port),
    .o_da_clk       (o_da_clk),
    .o_underrun     (o_underrun),
    .o_underrun_cnt (o_underrun_cnt),
    .o_level        (o_level)
  );

  always #20 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: sample queue plus position within the current sample period.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_dac;
  bit            m_clk, m_und, m_run, m_primed;
  int            m_cnt, m_pos, m_P;

  function automatic int period_of(input int d);
    return ((d < 1) ? 1 : d) + 1;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_dac = 8'h80; m_clk = 0; m_und = 0; m_cnt = 0;
    m_pos = 0; m_P = 2; m_run = 0; m_primed = 0;
  endtask

  task automatic model_edge();
    bit ready_pre;
    bit slot;
    if (!i_resetn) begin
      model_reset();
      return;
    end
    ready_pre = (mq.size() < DEPTH);
    slot = i_enable && m_run && (m_pos == m_P - 1);
    m_und = slot && (mq.size() == 0);
    if (m_und && m_cnt < 255) m_cnt++;
    if (slot && mq.size() > 0) m_dac = mq.pop_front();
    if (s_valid && ready_pre) mq.push_back(s_data);
    if (!i_enable) begin
      m_pos = 0; m_P = period_of(int'(i_div)); m_primed = 0;
    end else if (!m_run) begin
      m_pos = 0;
    end else if (m_pos == m_P - 1) begin
      m_pos = 0; m_P = period_of(int'(i_div));
    end else begin
      m_pos++;
    end
    if (slot) m_primed = 1;
    m_clk = i_enable && m_primed && (m_pos >= 1) && (m_pos <= m_P / 2);
    m_run = i_enable;
  endtask

  task automatic check_all();
    chk("da_port", 32'(o_da_port), 32'(m_dac));
    chk("da_clk", 32'(o_da_clk), 32'(m_clk));
    chk("underrun", 32'(o_underrun), 32'(m_und));
    chk("underrun_cnt", 32'(o_underrun_cnt), 32'(m_cnt));
    chk("level", 32'(o_level), 32'(mq.size()));
    chk("s_ready", 32'(s_ready), 32'(mq.size() < DEPTH));
  endtask

  task automatic step();
    @(posedge i_clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    i_resetn = 1'b0; i_enable = 1'b0; s_valid = 1'b0;
    step(); step();
    i_resetn = 1'b1;
  endtask

  initial begin
    bit found;
    model_reset();

    // Reset values
    do_reset();
    chk("rst_da_port", 32'(o_da_port), 32'h80);
    chk("rst_level", 32'(o_level), 32'd0);

    // Basic playback, P=2
    i_div = 16'd1;
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1; s_data = DW'(i * 17);
      step();
    end
    s_valid = 1'b0;
    chk("basic_level8", 32'(o_level), 32'd8);
    i_enable = 1'b1;
    step(); step();
    step();
    chk("first_data", 32'(o_da_port), 32'h00);
    chk("first_clk_low", 32'(o_da_clk), 32'd0);
    step();
    chk("first_clk_rise", 32'(o_da_clk), 32'd1);
    repeat (30) step();
    chk("basic_last", 32'(o_da_port), 32'h77);
    chk("basic_und_cnt", 32'(o_underrun_cnt), 32'd8);

    // Disable mid-period, then asynchronous reset mid-stream
    i_div = 16'd5;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = DW'($urandom); step();
    end
    s_valid = 1'b0;
    repeat (8) step();
    i_enable = 1'b0;
    step();
    chk("dis_clk_low", 32'(o_da_clk), 32'd0);
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = DW'($urandom); step();
    end
    s_valid = 1'b0;
    i_enable = 1'b1;
    repeat (9) step();
    #5 i_resetn = 1'b0;
    #1;
    model_reset();
    check_all();
    i_enable = 1'b0;
    step();
    i_resetn = 1'b1;

    // Full / backpressure, then drain at P=4
    i_div = 16'd3;
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'b1; s_data = DW'($urandom); step();
    end
    chk("bp_level_full", 32'(o_level), 32'd16);
    chk("bp_ready_low", 32'(s_ready), 32'd0);
    i_enable = 1'b1;
    for (int i = 0; i < 120; i++) begin
      s_data = DW'($urandom); step();
    end
    s_valid = 1'b0;
    repeat (80) step();

    // Rate change mid-period: P=5 then P=10
    do_reset();
    i_div = 16'd4;
    for (int i = 0; i < 6; i++) begin
      s_valid = 1'b1; s_data = DW'($urandom); step();
    end
    s_valid = 1'b0;
    i_enable = 1'b1;
    repeat (7) step();
    i_div = 16'd9;
    repeat (60) step();

    // Underrun saturation
    do_reset();
    i_div = 16'd1;
    i_enable = 1'b1;
    repeat (600) step();
    chk("sat_cnt", 32'(o_underrun_cnt), 32'd255);
    chk("sat_port", 32'(o_da_port), 32'h80);

    // Push exactly in a tick cycle with an empty FIFO
    do_reset();
    i_div = 16'd3;
    i_enable = 1'b1;
    repeat (10) step();
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (m_run && i_enable && (m_pos == m_P - 1)) begin
        found = 1;
        break;
      end
      step();
    end
    chk("tick_wait", 32'(found), 32'd1);
    s_valid = 1'b1; s_data = 8'h5A;
    step();
    s_valid = 1'b0;
    chk("tick_push_und", 32'(o_underrun), 32'd1);
    chk("tick_push_level", 32'(o_level), 32'd1);
    repeat (4) step();
    chk("tick_push_data", 32'(o_da_port), 32'h5A);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      s_valid = ($urandom_range(0, 99) < 45);
      s_data = DW'($urandom);
      if ($urandom_range(0, 99) < 3) i_div = VW'($urandom_range(0, 6));
      if ($urandom_range(0, 199) == 0) i_enable = ~i_enable;
      else if (!i_enable && $urandom_range(0, 19) == 0) i_enable = 1'b1;
      if ($urandom_range(0, 999) == 0) begin
        i_resetn = 1'b0; step(); i_resetn = 1'b1;
      end else begin
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
